// File: rtl/power_rail_monitor.sv
// power_rail_monitor: supervises the 3.3 V / 2.5 V / 1.2 V rails against their enables,
// checking rise/fall windows, dropout, stuck-on and ordering, with a first-fault latch.
module power_rail_monitor #(
    parameter int T_RISE = 8,
    parameter int T_FALL = 8,
    parameter int CW     = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en33,
    input  logic       en25,
    input  logic       en12,
    input  logic       pg33,
    input  logic       pg25,
    input  logic       pg12,
    input  logic       clear,
    output logic       pwr_ok,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_rail
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_RISING  = 3'd1,
        S_ON      = 3'd2,
        S_FALLING = 3'd3,
        S_FLT     = 3'd4
    } rail_state_e;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_RISE  = 3'd1;
    localparam logic [2:0] FC_DROP  = 3'd2;
    localparam logic [2:0] FC_FALL  = 3'd3;
    localparam logic [2:0] FC_STUCK = 3'd4;
    localparam logic [2:0] FC_ORDER = 3'd5;

    localparam logic [CW-1:0] RISE_LAST = CW'(T_RISE - 1);
    localparam logic [CW-1:0] FALL_LAST = CW'(T_FALL - 1);
    localparam logic [CW-1:0] TIMER_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Rail index 0 = 3.3 V, 1 = 2.5 V, 2 = 1.2 V; lower index wins simultaneous faults.
    function automatic logic [4:0] first_fault(input logic [2:0] c0,
                                               input logic [2:0] c1,
                                               input logic [2:0] c2);
        logic [4:0] sel;
        sel = {2'd0, FC_NONE};
        if (c0 != FC_NONE) begin
            sel = {2'd1, c0};
        end else if (c1 != FC_NONE) begin
            sel = {2'd2, c1};
        end else if (c2 != FC_NONE) begin
            sel = {2'd3, c2};
        end
        return sel;
    endfunction

    logic [2:0]  en_v;
    logic [2:0]  pg_meta_q;
    logic [2:0]  pg_sync_q;

    rail_state_e state_q [3];
    rail_state_e state_d [3];
    logic [CW-1:0] timer_q [3];
    logic [CW-1:0] timer_d [3];
    logic [2:0]  rail_code [3];
    logic [2:0]  order_ok;
    logic        any_fault;
    logic [4:0]  winner;

    logic        fault_q, fault_d;
    logic [2:0]  code_q, code_d;
    logic [1:0]  rail_q, rail_d;
    logic        pwr_ok_q, pwr_ok_d;

    assign en_v = {en12, en25, en33};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pg_meta_q <= 3'b000;
            pg_sync_q <= 3'b000;
        end else begin
            pg_meta_q <= {pg12, pg25, pg33};
            pg_sync_q <= pg_meta_q;
        end
    end

    always_comb begin
        order_ok[0] = 1'b1;
        order_ok[1] = (state_q[0] == S_ON);
        order_ok[2] = (state_q[1] == S_ON);
        any_fault   = 1'b0;
        for (int r = 0; r < 3; r++) begin
            state_d[r]   = state_q[r];
            timer_d[r]   = timer_q[r];
            rail_code[r] = FC_NONE;
            case (state_q[r])
                S_OFF: begin
                    if (en_v[r]) begin
                        state_d[r] = S_RISING;
                        timer_d[r] = '0;
                    end else if (pg_sync_q[r]) begin
                        rail_code[r] = FC_STUCK;
                    end
                end
                S_RISING: begin
                    if (pg_sync_q[r]) begin
                        if (order_ok[r]) begin
                            state_d[r] = S_ON;
                        end else begin
                            rail_code[r] = FC_ORDER;
                        end
                    end else if (!en_v[r]) begin
                        state_d[r] = S_FALLING;
                        timer_d[r] = '0;
                    end else begin
                        timer_d[r] = timer_q[r] + TIMER_ONE;
                        if (timer_q[r] == RISE_LAST) begin
                            rail_code[r] = FC_RISE;
                        end
                    end
                end
                S_ON: begin
                    if (!en_v[r]) begin
                        state_d[r] = S_FALLING;
                        timer_d[r] = '0;
                    end else if (!pg_sync_q[r]) begin
                        rail_code[r] = FC_DROP;
                    end
                end
                S_FALLING: begin
                    if (!pg_sync_q[r]) begin
                        state_d[r] = S_OFF;
                    end else if (en_v[r]) begin
                        // Re-enable while still good: goes straight back to ON, subject to ordering.
                        if (order_ok[r]) begin
                            state_d[r] = S_ON;
                        end else begin
                            rail_code[r] = FC_ORDER;
                        end
                    end else begin
                        timer_d[r] = timer_q[r] + TIMER_ONE;
                        if (timer_q[r] == FALL_LAST) begin
                            rail_code[r] = FC_FALL;
                        end
                    end
                end
                S_FLT: begin
                    if (clear) begin
                        state_d[r] = S_OFF;
                        timer_d[r] = '0;
                    end
                end
                default: begin
                    state_d[r] = S_OFF;
                    timer_d[r] = '0;
                end
            endcase
            if (rail_code[r] != FC_NONE) begin
                any_fault = 1'b1;
            end
        end
        // A fault on any rail shuts every rail FSM down together.
        if (any_fault) begin
            for (int r = 0; r < 3; r++) begin
                state_d[r] = S_FLT;
                timer_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 3; r++) begin
                state_q[r] <= S_OFF;
                timer_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 3; r++) begin
                state_q[r] <= state_d[r];
                timer_q[r] <= timer_d[r];
            end
        end
    end

    assign winner = first_fault(rail_code[0], rail_code[1], rail_code[2]);

    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        rail_d  = rail_q;
        if (clear) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
            rail_d  = 2'd0;
        end
        // A new fault on the clearing edge still gets captured.
        if (any_fault && (!fault_q || clear)) begin
            fault_d = 1'b1;
            code_d  = winner[2:0];
            rail_d  = winner[4:3];
        end
        pwr_ok_d = (state_q[0] == S_ON) && (state_q[1] == S_ON) &&
                   (state_q[2] == S_ON) && !fault_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
            rail_q   <= 2'd0;
            pwr_ok_q <= 1'b0;
        end else begin
            fault_q  <= fault_d;
            code_q   <= code_d;
            rail_q   <= rail_d;
            pwr_ok_q <= pwr_ok_d;
        end
    end

    assign pwr_ok     = pwr_ok_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_rail = rail_q;

endmodule

// File: doc/power_rail_monitor.md
# power_rail_monitor

Closed-loop supervisor for the board power rails. It watches the three rail enables (3.3 V, 2.5 V, 1.2 V) driven by the power sequencer and the power-good returns from the regulators. It checks that each rail reaches good within a rise window, stays good while enabled, discharges within a fall window, and never reports good while disabled. It also checks rail-good ordering, latches the first fault with a code and rail ID, and produces a registered `pwr_ok` for downstream logic.

## Interface
- `T_RISE`, 8: edges allowed in RISING for synchronized power-good to assert.
- `T_FALL`, 8: edges allowed in FALLING for synchronized power-good to deassert.
- `CW`, 5: timer width; must satisfy 2^CW > max(T_RISE, T_FALL).

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `en33`, `en25`, `en12` in 1 each: rail enables from the sequencer, synchronous to `clk`.
- `pg33`, `pg25`, `pg12` in 1 each: regulator power-good, asynchronous.
- `clear` in 1: single-cycle pulse that clears the fault latch.
- `pwr_ok` out 1: all rails ON and no fault.
- `fault` out 1: fault latched.
- `fault_code` out 3: 0 none, 1 rise timeout, 2 dropout, 3 fall timeout, 4 stuck-on, 5 order.
- `fault_rail` out 2: 0 none, 1 = 3.3 V, 2 = 2.5 V, 3 = 1.2 V.

## Operation
- Each `pgX` passes through a 2-flop synchronizer to give `pgX_s`. Enables are used directly.
- Each rail has one FSM with states OFF, RISING, ON, FALLING, FLT, plus a CW-bit timer.
- **OFF**
  - `en`=1 → RISING, timer=0.
  - `en`=0 and `pg_s`=1 → FLT, code 4.
- **RISING**
  - `pg_s`=1 → ON.
  - `en`=0 → FALLING, timer=0.
  - Otherwise timer+1. If timer==T_RISE-1 → FLT, code 1.
- **ON**
  - `en`=0 → FALLING, timer=0.
  - `pg_s`=0 → FLT, code 2.
- **FALLING**
  - `pg_s`=0 → OFF.
  - `en`=1 and `pg_s`=1 → ON.
  - Otherwise timer+1. If timer==T_FALL-1 → FLT, code 3.
- **Order check:** the 2.5 V FSM entering ON while the 3.3 V FSM is not ON → FLT, code 5. Likewise, the 1.2 V FSM entering ON while the 2.5 V FSM is not ON → FLT, code 5. The order check replaces the ON transition.
- **FLT:** the FSM holds until `clear`. On `clear`, every rail FSM returns to OFF with timer 0, and normal evaluation resumes the next edge.
- **Fault latch:**
  - On the first FLT entry, set `fault`=1 and capture `fault_code`/`fault_rail`.
  - Later faults do not overwrite the latch; their FSMs still go to FLT.
  - Any fault forces all rail FSMs to FLT on the same edge, including rails not at fault.
- **Simultaneous faults** on one edge: the lowest rail number wins (3.3 V > 2.5 V > 1.2 V). Each rail produces at most one fault per edge.
- **`clear` on the same edge as a new fault:** the new fault is captured (set wins) and FSMs go to FLT.
- **`pwr_ok`:** registered. It is 1 when all three FSMs are ON and `fault`=0, otherwise 0.
- **Timer:** unsigned CW-bit. It never wraps, because the timeout fires first.

## Timing
- **Reset:** all FSMs OFF, timers 0, synchronizers 0, `pwr_ok`=0, `fault`=0, `fault_code`=0, `fault_rail`=0. Reset is immediate on `reset_n` low, including mid-operation.
- **`pgX` latency:** raw `pgX` sampled at edge N gives `pgX_s` visible at edge N+2, so the FSM updates at N+2.
- **Rise/fall windows:** the fault is registered at the T_RISE-th (or T_FALL-th) edge after entering RISING (or FALLING) if `pg_s` never met the condition. Effective raw window is T-2 edges.
- **Fault outputs:** registered, valid the same edge the FSM enters FLT.
- **`pwr_ok`:** rises one edge after the last FSM enters ON. It falls one edge after any FSM leaves ON or `fault` sets.
- **`clear` on edge M:** `fault`, `fault_code` and `fault_rail` are 0 after M unless a new fault occurs at M. A stuck condition re-faults at M+1.
- **Glitches:** `pgX` glitches shorter than one clock period may be missed. Any glitch captured by the synchronizer is treated as real.

## Test plan
- **Normal ramp** (T_RISE=8): `en33`@0, `pg33`@2, `en25`@5, `pg25`@7, `en12`@11, `pg12`@12 → no fault; `pwr_ok`=1 at edge 15.
- **Rise timeout:** `en33` with `pg33`, then `en25`=1 with `pg25` held 0 → `fault`=1, `fault_code`=1, `fault_rail`=2 at the 8th edge after RISING entry; `pwr_ok` stays 0.
- **Dropout:** from full ON, `pg12` low for 1 cycle → code 2, rail 3 two edges after sampling; `pwr_ok`=0 the following edge.
- **Order and simultaneous faults:**
  - `en25`=1 and `pg25`=1 while the 3.3 V FSM is OFF → code 5, rail 2.
  - `pg33`=1 and `pg12`=1 with all enables 0 → code 4, rail 1.
- **Clear:** `clear` with `pg33` still stuck high → fault clears for one edge, then re-latches code 4, rail 1. `clear` with `pg33`=0 → all outputs 0 and FSMs OFF.
- **Reset and fall timeout:**
  - `reset_n` low while `pwr_ok`=1 → all outputs 0 immediately.
  - Powered down with `pg12` held 1 after `en12`=0 → code 3, rail 3 at edge 8 after FALLING entry.
